// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared encodings for the limit counter: counting-mode field and the
// RUN/HALT state of the control FSM.
// -----------------------------------------------------------------------------
package counter_pkg;

    // Counting-mode field as presented on i_MODE. The reserved code
    // behaves exactly like STOP.
    typedef enum logic [1:0] {
        MODE_STOP = 2'b00,
        MODE_WRAP = 2'b01,
        MODE_SAT  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage : counter_pkg

// File: rtl/ovf_event_counter.sv
// -----------------------------------------------------------------------------
// ovf_event_counter
// Saturating count of overflow/underflow events.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   clr    : clear count to zero
//   inc    : one event this cycle
//   count  : registered event count, sticks at all-ones
//
// A clear coincident with an event leaves the count at 1: the event is not
// lost to the clear.
// -----------------------------------------------------------------------------
module ovf_event_counter #(
    parameter int EVT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [EVT_BITS-1:0] count
);

    localparam logic [EVT_BITS-1:0] EVT_MAX = '1;
    localparam logic [EVT_BITS-1:0] EVT_ONE = EVT_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? EVT_ONE : '0;
        end else if (inc && (count != EVT_MAX)) begin
            count <= count + EVT_ONE;
        end
    end

endmodule : ovf_event_counter

// File: rtl/counter_limit_multi.sv
// -----------------------------------------------------------------------------
// counter_limit_multi
// Up/down counter bounded by a run-time limit, with STOP / WRAP / SAT
// behaviour at the boundary, a sticky overflow flag, a wrap pulse and a
// saturating event counter.
//
// Ports
//   i_CLK        : clock, rising edge
//   i_RST        : synchronous active-high reset
//   i_EN         : count enable
//   i_DIR        : 0 = up, 1 = down
//   i_MODE       : 00 STOP, 01 WRAP, 10 SAT, 11 = STOP
//   i_LIM        : inclusive upper limit, may change any cycle
//   i_LOAD       : load strobe (beats counting and clear)
//   i_LOAD_VAL   : value taken on i_LOAD, not clamped
//   i_CLR        : clear overflow flag and event count, release HALT
//   o_COUNT      : current count
//   o_OVERFLOW   : sticky boundary-event flag
//   o_WRAP       : one-cycle pulse following a WRAP-mode event
//   o_HALTED     : FSM is in HALT
//   o_EVT_CNT    : saturating number of boundary events
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module counter_limit_multi
    import counter_pkg::*;
#(
    parameter int COUNTER_BITS = 32,
    parameter int EVT_BITS     = 8
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_EN,
    input  logic                    i_DIR,
    input  logic [1:0]              i_MODE,
    input  logic [COUNTER_BITS-1:0] i_LIM,
    input  logic                    i_LOAD,
    input  logic [COUNTER_BITS-1:0] i_LOAD_VAL,
    input  logic                    i_CLR,
    output logic [COUNTER_BITS-1:0] o_COUNT,
    output logic                    o_OVERFLOW,
    output logic                    o_WRAP,
    output logic                    o_HALTED,
    output logic [EVT_BITS-1:0]     o_EVT_CNT
);

    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

    state_e                  state_q, state_d;
    logic [COUNTER_BITS-1:0] count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    wrap_q, wrap_d;
    logic                    evt_inc;
    logic                    evt_clr;
    logic                    bnd_event;
    mode_e                   mode;

    assign mode = mode_e'(i_MODE);

    // NOTE: every signal gets a default before any branch, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        wrap_d    = 1'b0;
        evt_inc   = 1'b0;
        evt_clr   = 1'b0;
        bnd_event = 1'b0;

        if (i_LOAD) begin
            // Load replaces the count and resumes; no step, flags untouched.
            count_d = i_LOAD_VAL;
            state_d = ST_RUN;
        end else begin
            if (i_CLR) begin
                ovf_d   = 1'b0;
                evt_clr = 1'b1;
                state_d = ST_RUN;
            end

            // Stepping is gated by the current state, so a clear issued in
            // HALT only resumes; counting starts on the following cycle.
            if (i_EN && (state_q == ST_RUN)) begin
                if (!i_DIR) begin
                    if (count_q >= i_LIM) begin
                        bnd_event = 1'b1;
                        unique case (mode)
                            MODE_WRAP: begin
                                count_d = '0;
                                wrap_d  = 1'b1;
                            end
                            MODE_SAT:  count_d = i_LIM;
                            default: begin
                                count_d = i_LIM;
                                state_d = ST_HALT;
                            end
                        endcase
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    if (count_q == '0) begin
                        bnd_event = 1'b1;
                        unique case (mode)
                            MODE_WRAP: begin
                                count_d = i_LIM;
                                wrap_d  = 1'b1;
                            end
                            MODE_SAT:  count_d = '0;
                            default: begin
                                count_d = '0;
                                state_d = ST_HALT;
                            end
                        endcase
                    end else if (count_q > i_LIM) begin
                        // Limit dropped below the count: pull back in range
                        // first rather than stepping.
                        count_d = i_LIM;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end

                // An event in the same cycle as a clear wins over the clear.
                if (bnd_event) begin
                    ovf_d   = 1'b1;
                    evt_inc = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= ST_RUN;
            count_q <= '0;
            ovf_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            wrap_q  <= wrap_d;
        end
    end

    ovf_event_counter #(
        .EVT_BITS (EVT_BITS)
    ) u_evt (
        .clk   (i_CLK),
        .rst   (i_RST),
        .clr   (evt_clr),
        .inc   (evt_inc),
        .count (o_EVT_CNT)
    );

    assign o_COUNT    = count_q;
    assign o_OVERFLOW = ovf_q;
    assign o_WRAP     = wrap_q;
    assign o_HALTED   = (state_q == ST_HALT);

endmodule : counter_limit_multi

// File: tb/tb_counter_limit_multi.sv
// -----------------------------------------------------------------------------
// tb_counter_limit_multi
// Directed bench for counter_limit_multi (COUNTER_BITS=8, EVT_BITS=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_limit_multi;

    localparam int CB = 8;
    localparam int EB = 2;

    logic          clk = 1'b0;
    logic          rst, en, dir, load, clr;
    logic [1:0]    mode;
    logic [CB-1:0] lim, load_val;
    logic [CB-1:0] count;
    logic          ovf, wrap, halted;
    logic [EB-1:0] evt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_limit_multi #(
        .COUNTER_BITS (CB),
        .EVT_BITS     (EB)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_EN       (en),
        .i_DIR      (dir),
        .i_MODE     (mode),
        .i_LIM      (lim),
        .i_LOAD     (load),
        .i_LOAD_VAL (load_val),
        .i_CLR      (clr),
        .o_COUNT    (count),
        .o_OVERFLOW (ovf),
        .o_WRAP     (wrap),
        .o_HALTED   (halted),
        .o_EVT_CNT  (evt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_cnt, input logic e_ovf,
                             input logic e_wrap, input logic e_halt, input logic [1:0] e_evt);
        check({tag, ".count"},  32'(count),  32'(e_cnt));
        check({tag, ".ovf"},    32'(ovf),    32'(e_ovf));
        check({tag, ".wrap"},   32'(wrap),   32'(e_wrap));
        check({tag, ".halted"}, 32'(halted), 32'(e_halt));
        check({tag, ".evt"},    32'(evt),    32'(e_evt));
    endtask

    initial begin
        logic [7:0] wrap_cnt [14];
        logic       wrap_pls [14];
        logic [7:0] stop_cnt [8];
        logic       stop_hlt [8];
        logic [7:0] sat_cnt  [5];
        logic [1:0] lim0_evt [6];

        wrap_cnt = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};
        wrap_pls = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        stop_cnt = '{1, 2, 3, 4, 5, 5, 5, 5};
        stop_hlt = '{0, 0, 0, 0, 0, 1, 1, 1};
        sat_cnt  = '{1, 0, 0, 0, 0};
        lim0_evt = '{1, 2, 3, 3, 3, 3};

        rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; clr = 1'b0;
        mode = 2'b00; lim = '0; load_val = '0;
        @(negedge clk);
        tick();
        check_all("reset", 0, 0, 0, 0, 0);

        // WRAP up to limit 5 for 14 clocks.
        rst = 1'b0; lim = 8'd5; mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            check($sformatf("wrap14[%0d].count", i), 32'(count), 32'(wrap_cnt[i]));
            check($sformatf("wrap14[%0d].wrap", i), 32'(wrap), 32'(wrap_pls[i]));
        end
        check_all("wrap14_end", 2, 1, 0, 0, 2);

        en = 1'b0;
        tick();
        check("hold_en0.count", 32'(count), 32'd2);

        // Load 3, then reset mid-count in WRAP.
        load = 1'b1; load_val = 8'd3;
        tick();
        check_all("load3", 3, 1, 0, 0, 2);
        load = 1'b0; en = 1'b1; rst = 1'b1;
        tick();
        check_all("rst_mid", 0, 0, 0, 0, 0);

        // STOP up to 5 for 8 clocks.
        rst = 1'b0; mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("stop8[%0d].count", i), 32'(count), 32'(stop_cnt[i]));
            check($sformatf("stop8[%0d].halted", i), 32'(halted), 32'(stop_hlt[i]));
        end
        check_all("stop8_end", 5, 1, 0, 1, 1);

        mode = 2'b01;
        tick();
        check_all("halt_mode_chg", 5, 1, 0, 1, 1);

        load = 1'b1; load_val = 8'd2;
        tick();
        check_all("halt_load2", 2, 1, 0, 0, 1);

        // Back to STOP, halt again, then reset while halted.
        load = 1'b0; mode = 2'b11;
        tick(); tick(); tick(); tick();
        check_all("stop_rsvd", 5, 1, 0, 1, 2);
        rst = 1'b1;
        tick();
        check_all("rst_halt", 0, 0, 0, 0, 0);

        // SAT down from 2 with limit 3.
        rst = 1'b0; lim = 8'd3; mode = 2'b10; dir = 1'b1;
        load = 1'b1; load_val = 8'd2;
        tick();
        check("sat_load.count", 32'(count), 32'd2);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat5[%0d].count", i), 32'(count), 32'(sat_cnt[i]));
            check($sformatf("sat5[%0d].wrap", i), 32'(wrap), 32'd0);
        end
        check_all("sat5_end", 0, 1, 0, 0, 3);

        en = 1'b0; clr = 1'b1;
        tick();
        check_all("clr", 0, 0, 0, 0, 0);

        // Limit shrinks under the count.
        clr = 1'b0; lim = 8'd5; load = 1'b1; load_val = 8'd4;
        tick();
        load = 1'b0; lim = 8'd2; mode = 2'b01; dir = 1'b0; en = 1'b1;
        tick();
        check_all("lim_shrink_up", 0, 1, 1, 0, 1);
        en = 1'b0; lim = 8'd5; load = 1'b1;
        tick();
        check_all("reload4", 4, 1, 0, 0, 1);
        load = 1'b0; lim = 8'd2; dir = 1'b1; en = 1'b1;
        tick();
        check_all("lim_shrink_dn", 2, 1, 0, 0, 1);
        tick(); tick();
        check("dn_to0.count", 32'(count), 32'd0);
        tick();
        check_all("wrap_dn", 2, 1, 1, 0, 2);

        // Clear coincident with an event.
        lim = 8'd0; dir = 1'b0; clr = 1'b1;
        tick();
        check_all("clr_evt", 0, 1, 1, 0, 1);
        clr = 1'b0;

        // SAT up clamps an out-of-range count to the limit.
        rst = 1'b1;
        tick();
        rst = 1'b0; lim = 8'd5; mode = 2'b10; en = 1'b0;
        load = 1'b1; load_val = 8'd9;
        tick();
        check("sat_load9.count", 32'(count), 32'd9);
        load = 1'b0; en = 1'b1;
        tick();
        check_all("sat_up_clamp", 5, 1, 0, 0, 1);
        tick();
        check_all("sat_up_hold", 5, 1, 0, 0, 2);

        // Limit 0 in WRAP: event every cycle, event counter saturates at 3.
        rst = 1'b1;
        tick();
        rst = 1'b0; lim = 8'd0; mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("lim0[%0d].evt", i), 32'(evt), 32'(lim0_evt[i]));
            check($sformatf("lim0[%0d].wrap", i), 32'(wrap), 32'd1);
            check($sformatf("lim0[%0d].count", i), 32'(count), 32'd0);
        end
        en = 1'b0;
        tick();
        check("lim0_stop.wrap", 32'(wrap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_counter_limit_multi
